// File: rtl/rx_bit_sampler_if.sv
// rtl/rx_bit_sampler_if.sv - serial line, control and sampled-bit bundle for rx_bit_sampler
interface rx_bit_sampler_if #(
    parameter int PRESC_W = 6
);
    logic               RX_IN;
    logic [PRESC_W-1:0] Prescale;
    logic               Sample_En;
    logic               Parity_En;
    logic               Sampled_bit;
    logic               Bit_Available;
    logic [3:0]         Bit_Cnt;
    logic [PRESC_W-1:0] Edge_Cnt;
    logic               Frame_Done;
    logic               Start_Glitch;

    modport master (
        output RX_IN, Prescale, Sample_En, Parity_En,
        input  Sampled_bit, Bit_Available, Bit_Cnt, Edge_Cnt, Frame_Done, Start_Glitch
    );

    modport slave (
        input  RX_IN, Prescale, Sample_En, Parity_En,
        output Sampled_bit, Bit_Available, Bit_Cnt, Edge_Cnt, Frame_Done, Start_Glitch
    );
endinterface

// File: rtl/rx_bit_sampler.sv
// rtl/rx_bit_sampler.sv - UART RX oversampling, 2-of-3 bit vote and frame timing; false-start abort under RX_START_GLITCH_CHK_EN
module rx_bit_sampler #(
    parameter int PRESC_W  = 6,
    parameter int FRAME_DW = 8
) (
    input logic             CLK,
    input logic             RST,
    rx_bit_sampler_if.slave rx_if
);
    localparam logic [3:0] LAST_NOPAR = 4'(FRAME_DW + 1);
    localparam logic [3:0] LAST_PAR   = 4'(FRAME_DW + 2);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [3:0]         bit_q, bit_d;
    logic [2:0]         shift_q, shift_d;
    logic               sbit_q, sbit_d;
    logic               bavail_q, bavail_d;
    logic               fdone_q, fdone_d;

    logic [PRESC_W-1:0] p_eff;
    logic [PRESC_W-1:0] h_c;
    logic [PRESC_W-1:0] h_m1;
    logic [PRESC_W-1:0] h_p1;
    logic [PRESC_W-1:0] tick_last;
    logic [PRESC_W-1:0] tick_pre_last;
    logic [3:0]         last_bit;
    logic               vote;
    logic               glitch;

    // Unsupported ratios fall back to 8 so the vote window always fits in the bit.
    always_comb begin
        if (presc_q == PRESC_W'(8) || presc_q == PRESC_W'(16) || presc_q == PRESC_W'(32)) begin
            p_eff = presc_q;
        end else begin
            p_eff = PRESC_W'(8);
        end
    end

    assign h_c           = p_eff >> 1;
    assign h_m1          = h_c - PRESC_W'(1);
    assign h_p1          = h_c + PRESC_W'(1);
    assign tick_last     = p_eff - PRESC_W'(1);
    assign tick_pre_last = p_eff - PRESC_W'(2);
    assign last_bit      = rx_if.Parity_En ? LAST_PAR : LAST_NOPAR;

    // All three samples are in place during the strobe cycle, so the vote is read straight from them.
    assign vote = (shift_q[0] & shift_q[1]) | (shift_q[0] & shift_q[2]) | (shift_q[1] & shift_q[2]);

`ifdef RX_START_GLITCH_CHK_EN
    assign glitch = bavail_q && (bit_q == 4'd0) && vote;
`else
    assign glitch = 1'b0;
`endif

    always_comb begin
        presc_d  = presc_q;
        edge_d   = edge_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        sbit_d   = sbit_q;
        bavail_d = 1'b0;
        fdone_d  = 1'b0;

        if (bavail_q) begin
            sbit_d = vote;
        end

        if (!rx_if.Sample_En) begin
            presc_d = rx_if.Prescale;
            edge_d  = '0;
            bit_d   = '0;
        end else if (glitch) begin
            edge_d = '0;
            bit_d  = '0;
        end else begin
            if (edge_q == tick_last) begin
                edge_d = '0;
                // Wrap also covers an illegal mid-frame Parity_En drop, keeping Bit_Cnt bounded.
                bit_d  = (bit_q >= last_bit) ? 4'd0 : bit_q + 4'd1;
            end else begin
                edge_d = edge_q + PRESC_W'(1);
            end

            if (edge_q == h_m1 || edge_q == h_c || edge_q == h_p1) begin
                shift_d = {shift_q[1:0], rx_if.RX_IN};
            end

            if (edge_q == h_p1) begin
                bavail_d = 1'b1;
            end

            if (edge_q == tick_pre_last && bit_q == last_bit) begin
                fdone_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q  <= PRESC_W'(8);
            edge_q   <= '0;
            bit_q    <= '0;
            shift_q  <= 3'b111;
            sbit_q   <= 1'b1;
            bavail_q <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sbit_q   <= sbit_d;
            bavail_q <= bavail_d;
            fdone_q  <= fdone_d;
        end
    end

    assign rx_if.Sampled_bit   = bavail_q ? vote : sbit_q;
    assign rx_if.Bit_Available = bavail_q;
    assign rx_if.Bit_Cnt       = bit_q;
    assign rx_if.Edge_Cnt      = edge_q;
    assign rx_if.Frame_Done    = fdone_q;
    assign rx_if.Start_Glitch  = glitch;
endmodule

// File: tb/tb_rx_bit_sampler.sv
// tb/tb_rx_bit_sampler.sv - directed and randomized frames for rx_bit_sampler against a tick-arithmetic model
module tb_rx_bit_sampler;
    logic CLK;
    logic RST;

    rx_bit_sampler_if #(.PRESC_W(6)) rx_if ();

    rx_bit_sampler #(.PRESC_W(6), .FRAME_DW(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (rx_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   wave [0:511];
    int   P, H, F, L, base;
    logic exp_sb;
    int   got [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    function automatic int maj(input int a, input int b, input int c);
        return ((a + b + c) >= 2) ? 1 : 0;
    endfunction

    // Line level per oversampling tick: start 0, data LSB first, optional even parity, stop 1.
    task automatic make_wave(input int p, input bit par, input int data, input bit noise);
        int l;
        int v;
        l = par ? 10 : 9;
        for (int k = 0; k < 512; k++) wave[k] = 1;
        for (int b = 0; b <= l; b++) begin
            if (b == 0) v = 0;
            else if (b <= 8) v = (data >> (b - 1)) & 1;
            else if (b == 9 && par) begin
                v = 0;
                for (int j = 0; j < 8; j++) v = v ^ ((data >> j) & 1);
            end else v = 1;
            for (int k = 0; k < p; k++)
                wave[b * p + k] = (noise && $urandom_range(0, 7) == 0) ? 1 - v : v;
        end
    endtask

    // State i = outputs after i rising edges with Sample_En high.
    task automatic check_state(input int i);
        int t, b, k, v;
        bit ba;
        t  = (i - base) % F;
        b  = t / P;
        k  = t % P;
        ba = (k == H + 2);
        v  = 0;
        if (ba) begin
            v = maj(wave[i-3], wave[i-2], wave[i-1]);
            exp_sb = v[0];
        end
        if (rx_if.Bit_Available) got.push_back(int'(rx_if.Sampled_bit));
        chk("edge_cnt", 32'(rx_if.Edge_Cnt), k);
        chk("bit_cnt", 32'(rx_if.Bit_Cnt), b);
        chk("bit_available", 32'(rx_if.Bit_Available), 32'(ba));
        chk("sampled_bit", 32'(rx_if.Sampled_bit), 32'(exp_sb));
        chk("frame_done", 32'(rx_if.Frame_Done), 32'(t == F - 1));
`ifdef RX_START_GLITCH_CHK_EN
        chk("start_glitch", 32'(rx_if.Start_Glitch), 32'(ba && b == 0 && v == 1));
        if (ba && b == 0 && v == 1) base = i + 1;
`else
        chk("start_glitch", 32'(rx_if.Start_Glitch), 0);
`endif
    endtask

    task automatic frame(input int pin, input bit par, input int nst, input bit poke, input bit rst_mid);
        rx_if.Prescale  = 6'(pin);
        rx_if.Parity_En = par;
        rx_if.Sample_En = 1'b0;
        rx_if.RX_IN     = 1'b1;
        repeat (2) @(negedge CLK);
        P    = eff(pin);
        H    = P / 2;
        L    = par ? 10 : 9;
        F    = P * (L + 1);
        base = 0;
        got.delete();
        for (int i = 0; i < nst; i++) begin
            check_state(i);
            rx_if.Sample_En = 1'b1;
            rx_if.RX_IN     = (wave[i] != 0);
            if (poke && i == 5) rx_if.Prescale = 6'd32;
            @(negedge CLK);
        end
        check_state(nst);
        if (rst_mid) begin
            #2 RST = 1'b0;
            #1;
            chk("rst_edge", 32'(rx_if.Edge_Cnt), 0);
            chk("rst_bit", 32'(rx_if.Bit_Cnt), 0);
            chk("rst_bavail", 32'(rx_if.Bit_Available), 0);
            chk("rst_fdone", 32'(rx_if.Frame_Done), 0);
            chk("rst_glitch", 32'(rx_if.Start_Glitch), 0);
            chk("rst_sbit", 32'(rx_if.Sampled_bit), 1);
            @(negedge CLK);
            RST    = 1'b1;
            exp_sb = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge CLK);
                chk("restart_edge", 32'(rx_if.Edge_Cnt), k);
                chk("restart_bit", 32'(rx_if.Bit_Cnt), 0);
            end
        end
        rx_if.Sample_En = 1'b0;
        rx_if.RX_IN     = 1'b1;
        @(negedge CLK);
        chk("idle_edge", 32'(rx_if.Edge_Cnt), 0);
        chk("idle_bit", 32'(rx_if.Bit_Cnt), 0);
        chk("idle_bavail", 32'(rx_if.Bit_Available), 0);
        chk("idle_fdone", 32'(rx_if.Frame_Done), 0);
    endtask

    initial begin
        int          pins [7];
        int          pin, p, par, l;
        logic [10:0] seq;

        pins = '{8, 16, 32, 5, 0, 63, 12};
        RST             = 1'b0;
        rx_if.Sample_En = 1'b0;
        rx_if.Parity_En = 1'b0;
        rx_if.Prescale  = 6'd8;
        rx_if.RX_IN     = 1'b1;
        exp_sb          = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_edge", 32'(rx_if.Edge_Cnt), 0);
        chk("reset_bit", 32'(rx_if.Bit_Cnt), 0);
        chk("reset_bavail", 32'(rx_if.Bit_Available), 0);
        chk("reset_fdone", 32'(rx_if.Frame_Done), 0);
        chk("reset_glitch", 32'(rx_if.Start_Glitch), 0);
        chk("reset_sbit", 32'(rx_if.Sampled_bit), 1);
        RST = 1'b1;
        @(negedge CLK);

        make_wave(8, 1'b1, 'hA5, 1'b0);
        frame(8, 1'b1, 88, 1'b0, 1'b0);
        chk("a5_strobes", got.size(), 11);
        seq = '0;
        for (int j = 0; j < 11 && j < got.size(); j++) seq[j] = got[j][0];
        chk("a5_bits", 32'(seq), 32'(11'b10101001010));

        make_wave(16, 1'b0, 'h3C, 1'b0);
        frame(16, 1'b0, 160, 1'b0, 1'b0);
        chk("3c_strobes", got.size(), 10);

        make_wave(8, 1'b0, int'($urandom) | 4, 1'b0);
        wave[3*8+4] = 0;
        frame(8, 1'b0, 80, 1'b0, 1'b0);
        chk("tick4_glitch_bit3", got[3], 1);

        make_wave(8, 1'b1, int'($urandom), 1'b0);
        frame(5, 1'b1, 88, 1'b1, 1'b0);

        make_wave(8, 1'b1, int'($urandom), 1'b0);
        frame(8, 1'b1, 35, 1'b0, 1'b1);

        make_wave(8, 1'b0, int'($urandom), 1'b0);
        for (int k = 3; k <= 5; k++) wave[k] = 1;
        frame(8, 1'b0, 80, 1'b0, 1'b0);
        chk("start_vote", got[0], 1);

        make_wave(16, 1'b1, int'($urandom), 1'b1);
        frame(16, 1'b1, 100, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            pin = pins[$urandom_range(0, 6)];
            p   = eff(pin);
            par = int'($urandom_range(0, 1));
            l   = (par != 0) ? 10 : 9;
            make_wave(p, par[0], int'($urandom), 1'b1);
            frame(pin, par[0], p * (l + 1), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
